// File: rtl/channel_rob_if.sv
// Channel-side bus of the response reorder buffer: allocation, bank fill and
// in-order response signals. The master modport is the channel/crossbar side,
// the slave modport is the reorder buffer itself.
interface channel_rob_if #(
  parameter int ROB_SIZE = 16,
  parameter int DATA_W   = 128
);
  localparam int ROB_W = $clog2(ROB_SIZE);

  logic              alloc_valid;
  logic              alloc_ready;
  logic [ROB_W-1:0]  alloc_rob_id;
  logic              fill_valid;
  logic [ROB_W-1:0]  fill_rob_id;
  logic [DATA_W-1:0] fill_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ROB_W:0]    rob_count;
  logic              fill_err;

  modport master (
    output alloc_valid, fill_valid, fill_rob_id, fill_data, rsp_ready,
    input  alloc_ready, alloc_rob_id, rsp_valid, rsp_rdata, rob_count, fill_err
  );

  modport slave (
    input  alloc_valid, fill_valid, fill_rob_id, fill_data, rsp_ready,
    output alloc_ready, alloc_rob_id, rsp_valid, rsp_rdata, rob_count, fill_err
  );
endinterface

// File: rtl/channel_rob.sv
// Per-channel response reorder buffer. Hands out rob_ids in order, captures
// out-of-order bank fills tagged with those ids, and releases data to the
// channel strictly in allocation order.
// Optional macro CHANNEL_ROB_BYPASS_EN: a fill that targets a PENDING head is
// presented on the response bus combinationally in the same cycle.
module channel_rob #(
  parameter int ROB_SIZE = 16,
  parameter int DATA_W   = 128
) (
  input  logic          clk,
  input  logic          rst,
  channel_rob_if.slave  bus
);
  localparam int ROB_W = $clog2(ROB_SIZE);

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_DONE    = 2'd2
  } entry_state_e;

  entry_state_e      st_q [ROB_SIZE];
  entry_state_e      st_d [ROB_SIZE];
  logic [DATA_W-1:0] data_q [ROB_SIZE];
  logic [ROB_W-1:0]  head_q;
  logic [ROB_W-1:0]  tail_q;
  logic [ROB_W:0]    count_q;
  logic              err_q;

  logic              alloc_ready;
  logic              alloc_fire;
  logic              fill_ok;
  logic              head_done;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fire;

  // Handshake qualification and response presentation.
  always_comb begin
    alloc_ready = count_q < (ROB_W+1)'(ROB_SIZE);
    alloc_fire  = bus.alloc_valid && alloc_ready;
    fill_ok     = bus.fill_valid && (st_q[bus.fill_rob_id] == ST_PENDING);
    head_done   = (st_q[head_q] == ST_DONE);
`ifdef CHANNEL_ROB_BYPASS_EN
    // A fill into a PENDING head is forwarded straight to the channel; head is
    // never DONE in that case, so the two sources are mutually exclusive.
    if (bus.fill_valid && (bus.fill_rob_id == head_q) && (st_q[head_q] == ST_PENDING)) begin
      rsp_valid = 1'b1;
      rsp_rdata = bus.fill_data;
    end else begin
      rsp_valid = head_done;
      rsp_rdata = head_done ? data_q[head_q] : '0;
    end
`else
    rsp_valid = head_done;
    rsp_rdata = head_done ? data_q[head_q] : '0;
`endif
    rsp_fire = rsp_valid && bus.rsp_ready;
  end

  // Next entry states; release is applied last so a bypassed fill that is
  // accepted in the same cycle leaves the entry FREE rather than DONE.
  always_comb begin
    st_d = st_q;
    if (fill_ok)    st_d[bus.fill_rob_id] = ST_DONE;
    if (alloc_fire) st_d[tail_q]          = ST_PENDING;
    if (rsp_fire)   st_d[head_q]          = ST_FREE;
  end

  // Entry states, pointers, occupancy and the fill error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= '{default: ST_FREE};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      tail_q  <= tail_q + ROB_W'(alloc_fire);
      head_q  <= head_q + ROB_W'(rsp_fire);
      count_q <= count_q + (ROB_W+1)'(alloc_fire) - (ROB_W+1)'(rsp_fire);
      err_q   <= bus.fill_valid && !fill_ok;
    end
  end

  // Data storage; contents are don't-care until an entry is filled.
  always_ff @(posedge clk) begin
    if (fill_ok) data_q[bus.fill_rob_id] <= bus.fill_data;
  end

  assign bus.alloc_ready  = alloc_ready;
  assign bus.alloc_rob_id = tail_q;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_rdata    = rsp_rdata;
  assign bus.rob_count    = count_q;
  assign bus.fill_err     = err_q;
endmodule

// File: tb/tb_channel_rob.sv
// Testbench for channel_rob: directed scenarios followed by random traffic,
// checked against a queue-based reference model through a scoreboard.
module tb_channel_rob;
  localparam int N = 16;
  localparam int DW = 128;
  localparam int FREE = 0, PEND = 1, DONE = 2;

  logic clk = 1'b0;
  logic rst;

  channel_rob_if #(.ROB_SIZE(N), .DATA_W(DW)) bus ();

  channel_rob #(.ROB_SIZE(N), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cnt;
    bit          rdy;
    int          tail;
    bit          err;
    bit          vld;
    logic [DW-1:0] data;
  } status_t;

  status_t       stat_q[$];
  logic [DW-1:0] rel_q[$];

  int checks = 0;
  int passed = 0;

  // Reference model: per-id state/data plus the ordered list of live ids.
  int            mstate [N];
  logic [DW-1:0] mdata  [N];
  int            mtail;
  int            aq[$];
  bit            merr;

  function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void model_reset();
    foreach (mstate[i]) mstate[i] = FREE;
    mtail = 0;
    aq.delete();
    merr = 1'b0;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: compares every cycle's outputs and every accepted response.
  always @(negedge clk) begin
    status_t s;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      check("rob_count", DW'(bus.rob_count), DW'(s.cnt));
      check("alloc_ready", DW'(bus.alloc_ready), DW'(s.rdy));
      if (s.rdy) check("alloc_rob_id", DW'(bus.alloc_rob_id), DW'(s.tail));
      check("fill_err", DW'(bus.fill_err), DW'(s.err));
      check("rsp_valid", DW'(bus.rsp_valid), DW'(s.vld));
      if (s.vld) check("rsp_rdata", bus.rsp_rdata, s.data);
    end
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (rel_q.size() == 0) begin
        checks++;
        $display("FAIL release: unexpected response %0h, none expected", bus.rsp_rdata);
      end else begin
        check("release_data", bus.rsp_rdata, rel_q.pop_front());
      end
    end
  end

  // One clock of stimulus; the model predicts this cycle's outputs, then
  // advances to the state after the next edge.
  task automatic cycle(input bit r, input bit av, input bit fv, input int fid,
                       input logic [DW-1:0] fd, input bit rr);
    status_t s;
    int head, cnt;
    bit vld, err_n, afire;
    logic [DW-1:0] dat;
    rst             = r;
    bus.alloc_valid = av;
    bus.fill_valid  = fv;
    bus.fill_rob_id = 4'(fid);
    bus.fill_data   = fd;
    bus.rsp_ready   = rr;
    cnt  = aq.size();
    head = (cnt > 0) ? aq[0] : mtail;
    vld  = (mstate[head] == DONE);
    dat  = vld ? mdata[head] : '0;
`ifdef CHANNEL_ROB_BYPASS_EN
    if (!vld && fv && fid == head && mstate[head] == PEND) begin
      vld = 1'b1;
      dat = fd;
    end
`endif
    s.cnt = cnt; s.rdy = (cnt < N); s.tail = mtail; s.err = merr;
    s.vld = vld; s.data = dat;
    stat_q.push_back(s);
    if (vld && rr) rel_q.push_back(dat);
    if (r) begin
      model_reset();
    end else begin
      err_n = fv && (mstate[fid] != PEND);
      afire = av && (cnt < N);
      if (fv && mstate[fid] == PEND) begin
        mstate[fid] = DONE;
        mdata[fid]  = fd;
      end
      if (afire) begin
        mstate[mtail] = PEND;
        aq.push_back(mtail);
        mtail = (mtail + 1) % N;
      end
      if (vld && rr) begin
        mstate[head] = FREE;
        void'(aq.pop_front());
      end
      merr = err_n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, rr);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, '0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int fid;
    int pl[$];
    rst = 1'b1;
    bus.alloc_valid = 1'b0;
    bus.fill_valid  = 1'b0;
    bus.fill_rob_id = '0;
    bus.fill_data   = '0;
    bus.rsp_ready   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_rsp_rdata", bus.rsp_rdata, '0);
    do_reset();

    // In-order release of out-of-order fills.
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, '0, 1);
    cycle(0, 0, 1, 2, 128'hCCCC, 1);
    cycle(0, 0, 1, 0, 128'hAAAA, 1);
    cycle(0, 0, 1, 1, 128'hBBBB, 1);
    idle(4, 1);

    // Full buffer, release one, wrap of the tail onto id 0.
    do_reset();
    for (int i = 0; i < N; i++) cycle(0, 1, 0, 0, '0, 0);
    cycle(0, 1, 0, 0, '0, 0);
    cycle(0, 0, 1, 0, 128'h1234, 0);
    cycle(0, 0, 0, 0, '0, 1);
    cycle(0, 1, 0, 0, '0, 0);
    idle(2, 0);

    // Backpressure holds the response stable.
    do_reset();
    cycle(0, 1, 0, 0, '0, 0);
    cycle(0, 0, 1, 0, 128'h5A5A, 0);
    idle(5, 0);
    idle(2, 1);

    // Fill errors: FREE target, then an already-DONE target.
    do_reset();
    cycle(0, 0, 1, 5, 128'hDEAD, 1);
    idle(1, 1);
    cycle(0, 1, 0, 0, '0, 0);
    cycle(0, 1, 0, 0, '0, 0);
    cycle(0, 0, 1, 1, 128'h0101, 0);
    cycle(0, 0, 1, 1, 128'hBEEF, 0);
    idle(2, 0);
    cycle(0, 0, 1, 0, 128'h0000, 1);
    idle(3, 1);

    // Simultaneous alloc, non-head fill and head release at count 4.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, '0, 0);
    cycle(0, 0, 1, 0, 128'h7777, 0);
    cycle(0, 1, 1, 2, 128'h2222, 1);
    idle(1, 0);

    // Reset with entries outstanding.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, '0, 0);
    cycle(0, 0, 1, 0, 128'h6666, 0);
    do_reset();
    idle(2, 1);

    // Fill of a PENDING head with the channel ready.
    cycle(0, 1, 0, 0, '0, 1);
    cycle(0, 0, 1, 0, 128'h9999, 1);
    idle(2, 1);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      pl.delete();
      foreach (aq[i]) if (mstate[aq[i]] == PEND) pl.push_back(aq[i]);
      if (pl.size() > 0 && $urandom_range(0, 9) < 8) fid = pl[$urandom_range(0, pl.size() - 1)];
      else fid = $urandom_range(0, N - 1);
      cycle(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, fid, rnd_data(), $urandom_range(0, 9) < 7);
    end

    // Drain: fill whatever is still pending, then accept everything.
    pl.delete();
    foreach (aq[i]) if (mstate[aq[i]] == PEND) pl.push_back(aq[i]);
    foreach (pl[i]) cycle(0, 0, 1, pl[i], rnd_data(), 1);
    idle(N + 4, 1);
    @(negedge clk);
    #1;
    check("drain_releases", DW'(rel_q.size()), '0);
    check("drain_count", DW'(bus.rob_count), DW'(aq.size()));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
